// File: rtl/deconcatenator.sv
// Splits a continuous word stream into frames of NUM_WORDS words. Each accepted word is tagged
// with first/last markers and parked in a 2-entry skid buffer that absorbs downstream stalls.
module deconcatenator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned FCNT_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_resync,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_first,
  output logic                  o_out_last,
  output logic [FCNT_WIDTH-1:0] o_frame_count
);

  // A 1-word frame still needs a 1-bit index register.
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  if ((NUM_WORDS < 1) || (NUM_WORDS > 65536)) begin : g_bad_num_words
    $error("deconcatenator: NUM_WORDS must be in 1..65536");
  end

  logic [WIDTH-1:0]      data_q [2];
  logic [1:0]            first_q;
  logic [1:0]            last_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic [FCNT_WIDTH-1:0] fcnt_q;

  logic             push;
  logic             pop;
  logic [IDX_W-1:0] tag_idx;
  logic             tag_first;
  logic             tag_last;

  // Handshakes, tag of the incoming word and next frame index.
  always_comb begin
    push      = i_in_valid && o_in_ready;
    pop       = o_out_valid && i_out_ready;
    // A resync forces the word accepted in the same cycle to start a new frame.
    tag_idx   = i_resync ? '0 : idx_q;
    tag_first = (tag_idx == '0);
    tag_last  = (tag_idx == LAST_IDX);
    idx_d     = idx_q;
    if (push) begin
      idx_d = tag_last ? '0 : tag_idx + 1'b1;
    end else if (i_resync) begin
      idx_d = '0;
    end
  end

  // Buffer storage, pointers, occupancy, frame index and frame counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      first_q   <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      idx_q     <= '0;
      fcnt_q    <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q]  <= i_in_data;
        first_q[wr_ptr_q] <= tag_first;
        last_q[wr_ptr_q]  <= tag_last;
        wr_ptr_q          <= ~wr_ptr_q;
        if (tag_last) begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      idx_q <= idx_d;
    end
  end

  // Outputs come from registered state only; ready never depends on i_out_ready.
  always_comb begin
    o_in_ready    = (count_q < 2'd2);
    o_out_valid   = (count_q != 2'd0);
    o_out_data    = data_q[rd_ptr_q];
    o_out_first   = o_out_valid && first_q[rd_ptr_q];
    o_out_last    = o_out_valid && last_q[rd_ptr_q];
    o_frame_count = fcnt_q;
  end

endmodule
